// File: rtl/ctr_share_pkg.sv
// Shared constants and helpers for the time-multiplexed counter bank.
// Top-level parameters default to the values held here.
package ctr_share_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CTR_W  = 8;
    localparam int DEF_PEND_W = 2;

    // Largest channel count the bank supports; sizes the one-hot helper.
    localparam int MAX_CH     = 8;

    // Channel index width for the default bank size.
    localparam int CH_IDX_W   = $clog2(DEF_NUM_CH);

    // Deepest pending-event backlog a channel can hold before dropping events.
    localparam int PEND_MAX   = (1 << DEF_PEND_W) - 1;

    // One-hot encode a channel index into a MAX_CH-wide vector.
    function automatic logic [MAX_CH-1:0] onehot(input logic [31:0] idx);
        logic [MAX_CH-1:0] v;
        v = '0;
        if (idx < MAX_CH) begin
            v[idx[2:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/ctr_share_sched_rr_arb.sv
// Round-robin arbiter: picks the first eligible channel after the pointer.
// Purely combinational; the caller owns the pointer register.
module rr_arb #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [IDX_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [IDX_W-1:0]  gnt_idx
);

    int cand;

    // Walk channels ptr+1 .. ptr+NUM_CH (wrapping) and latch the first eligible one.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!gnt_valid && eligible[cand[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ctr_share_sched.sv
// Counter bank with NUM_CH channels sharing one incrementer.
// Events queue per channel in a small pending counter; a round-robin
// arbiter hands the incrementer to one pending channel per cycle.
module ctr_share_sched
    import ctr_share_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CTR_W  = DEF_CTR_W,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [NUM_CH-1:0]         clr_i,
    input  logic [$clog2(NUM_CH)-1:0] sel_i,
    output logic [CTR_W-1:0]          rd_data_o,
    output logic [NUM_CH-1:0]         gnt_o,
    output logic [NUM_CH-1:0]         wrap_o,
    output logic [NUM_CH-1:0]         drop_o,
    output logic                      busy_o
);

    localparam int                IDX_W     = $clog2(NUM_CH);
    localparam logic [PEND_W-1:0] PEND_FULL = '1;
    localparam logic [CTR_W-1:0]  CTR_FULL  = '1;

    logic [CTR_W-1:0]  ctr  [NUM_CH];
    logic [PEND_W-1:0] pend [NUM_CH];
    logic [IDX_W-1:0]  ptr;

    logic [NUM_CH-1:0] eligible;
    logic              gnt_valid;
    logic [IDX_W-1:0]  gnt_idx;
    logic [NUM_CH-1:0] grant_vec;
    logic [CTR_W-1:0]  ctr_sel;
    logic [CTR_W-1:0]  ctr_next;

    // A channel may compete only if it has queued events and is not being cleared.
    always_comb begin
        eligible = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c] = (pend[c] != '0) && !clr_i[c];
        end
    end

    rr_arb #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Expand the winning index into a per-channel grant strobe.
    always_comb begin
        grant_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            grant_vec[c] = gnt_valid && (gnt_idx == IDX_W'(c));
        end
    end

    // The single shared incrementer operates on whichever counter won arbitration.
    always_comb begin
        ctr_sel  = ctr[gnt_idx];
        ctr_next = ctr_sel + CTR_W'(1);
    end

    // Per-channel counter, pending backlog and sticky flags; clear beats everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ctr[c]  <= '0;
                pend[c] <= '0;
            end
            wrap_o <= '0;
            drop_o <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr_i[c]) begin
                    ctr[c]    <= '0;
                    pend[c]   <= '0;
                    wrap_o[c] <= 1'b0;
                    drop_o[c] <= 1'b0;
                end else begin
                    if (grant_vec[c]) begin
                        ctr[c] <= ctr_next;
                        if (ctr_sel == CTR_FULL) begin
                            wrap_o[c] <= 1'b1;
                        end
                    end
                    case ({req_i[c], grant_vec[c]})
                        2'b10: begin
                            if (pend[c] == PEND_FULL) begin
                                drop_o[c] <= 1'b1;
                            end else begin
                                pend[c] <= pend[c] + PEND_W'(1);
                            end
                        end
                        2'b01: begin
                            pend[c] <= pend[c] - PEND_W'(1);
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Round-robin pointer follows the last winner; grant strobe is registered for readback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= IDX_W'(NUM_CH - 1);
            gnt_o <= '0;
        end else begin
            gnt_o <= grant_vec;
            if (gnt_valid) begin
                ptr <= gnt_idx;
            end
        end
    end

    // Busy whenever any channel still has queued events.
    always_comb begin
        busy_o = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            busy_o = busy_o | (pend[c] != '0);
        end
    end

    // Readback mux over the registered counters.
    always_comb begin
        rd_data_o = ctr[sel_i];
    end

endmodule

// File: tb/tb_ctr_share_sched.sv
// Directed bench for the shared-incrementer counter bank (4 channels, 8-bit counters).
module tb_ctr_share_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] clr_i;
    logic [1:0] sel_i;
    logic [7:0] rd_data_o;
    logic [3:0] gnt_o;
    logic [3:0] wrap_o;
    logic [3:0] drop_o;
    logic       busy_o;

    int n_checks;
    int n_fail;

    ctr_share_sched #(
        .NUM_CH (4),
        .CTR_W  (8),
        .PEND_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .clr_i     (clr_i),
        .sel_i     (sel_i),
        .rd_data_o (rd_data_o),
        .gnt_o     (gnt_o),
        .wrap_o    (wrap_o),
        .drop_o    (drop_o),
        .busy_o    (busy_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and land 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clear every channel for one cycle.
    task automatic clear_all();
        clr_i = 4'b1111;
        tick();
        clr_i = 4'b0000;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b0; req_i = '0; clr_i = '0; sel_i = '0;
        #1 rst = 1'b1;
        #2;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt_o, 4'b0000); end
        n_checks++; if (wrap_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_wrap: got %b expected %b", wrap_o, 4'b0000); end
        n_checks++; if (drop_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_drop: got %b expected %b", drop_o, 4'b0000); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (rd_data_o !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_rd: got %0d expected 0", rd_data_o); end
        #10 rst = 1'b0;
    endtask

    task automatic test_single();
        $display("[TB] test_single");
        sel_i = 2'd0;
        req_i = 4'b0001;
        tick();
        req_i = 4'b0000;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy: got %b expected 1", busy_o); end
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_gnt_early: got %b expected %b", gnt_o, 4'b0000); end
        tick();
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_gnt: got %b expected %b", gnt_o, 4'b0001); end
        n_checks++; if (rd_data_o !== 8'd1) begin n_fail++; $display("[TB] FAIL single_ctr: got %0d expected 1", rd_data_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle: got %b expected 0", busy_o); end
        for (int n = 2; n <= 300; n++) begin
            req_i = 4'b0001;
            tick();
            req_i = 4'b0000;
            tick();
            if (n == 255) begin
                n_checks++; if (rd_data_o !== 8'd255) begin n_fail++; $display("[TB] FAIL single_ctr_max: got %0d expected 255", rd_data_o); end
                n_checks++; if (wrap_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_nowrap: got %b expected %b", wrap_o, 4'b0000); end
            end
            if (n == 256) begin
                n_checks++; if (rd_data_o !== 8'd0) begin n_fail++; $display("[TB] FAIL single_ctr_wrap: got %0d expected 0", rd_data_o); end
                n_checks++; if (wrap_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_wrap_set: got %b expected %b", wrap_o, 4'b0001); end
            end
        end
        n_checks++; if (rd_data_o !== 8'd44) begin n_fail++; $display("[TB] FAIL single_ctr300: got %0d expected 44", rd_data_o); end
        n_checks++; if (wrap_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_wrap_sticky: got %b expected %b", wrap_o, 4'b0001); end
        n_checks++; if (drop_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_nodrop: got %b expected %b", drop_o, 4'b0000); end
        clear_all();
        n_checks++; if (rd_data_o !== 8'd0) begin n_fail++; $display("[TB] FAIL single_clr_ctr: got %0d expected 0", rd_data_o); end
        n_checks++; if (wrap_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_clr_wrap: got %b expected %b", wrap_o, 4'b0000); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_gnt;
        logic [7:0] exp_ctr [4];
        exp_ctr = '{8'd6, 8'd6, 8'd6, 8'd5};
        $display("[TB] test_fairness");
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        req_i = 4'b1111;
        tick();
        for (int k = 2; k <= 24; k++) begin
            if (k == 13) req_i = 4'b0000;
            tick();
            exp_gnt = 4'b0001 << ((k - 2) % 4);
            n_checks++; if (gnt_o !== exp_gnt) begin n_fail++; $display("[TB] FAIL fair_gnt_%0d: got %b expected %b", k, gnt_o, exp_gnt); end
            n_checks++; if (busy_o !== (k < 24)) begin n_fail++; $display("[TB] FAIL fair_busy_%0d: got %b expected %b", k, busy_o, (k < 24)); end
        end
        n_checks++; if (drop_o !== 4'b1111) begin n_fail++; $display("[TB] FAIL fair_drop: got %b expected %b", drop_o, 4'b1111); end
        n_checks++; if (wrap_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL fair_wrap: got %b expected %b", wrap_o, 4'b0000); end
        for (int c = 0; c < 4; c++) begin
            sel_i = 2'(c);
            tick();
            n_checks++; if (rd_data_o !== exp_ctr[c]) begin n_fail++; $display("[TB] FAIL fair_ctr_%0d: got %0d expected %0d", c, rd_data_o, exp_ctr[c]); end
        end
    endtask

    task automatic test_pending_balance();
        $display("[TB] test_pending_balance");
        clear_all();
        sel_i = 2'd2;
        req_i = 4'b0100;
        tick();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL bal_busy: got %b expected 1", busy_o); end
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL bal_gnt_first: got %b expected %b", gnt_o, 4'b0000); end
        for (int k = 2; k <= 8; k++) begin
            tick();
            n_checks++; if (gnt_o !== 4'b0100) begin n_fail++; $display("[TB] FAIL bal_gnt_%0d: got %b expected %b", k, gnt_o, 4'b0100); end
            n_checks++; if (rd_data_o !== 8'(k - 1)) begin n_fail++; $display("[TB] FAIL bal_ctr_%0d: got %0d expected %0d", k, rd_data_o, k - 1); end
            n_checks++; if (drop_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL bal_drop_%0d: got %b expected %b", k, drop_o, 4'b0000); end
        end
        req_i = 4'b0000;
        tick();
        n_checks++; if (rd_data_o !== 8'd8) begin n_fail++; $display("[TB] FAIL bal_ctr_final: got %0d expected 8", rd_data_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bal_idle: got %b expected 0", busy_o); end
        tick();
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL bal_gnt_idle: got %b expected %b", gnt_o, 4'b0000); end
    endtask

    task automatic test_clear_collision();
        $display("[TB] test_clear_collision");
        clear_all();
        req_i = 4'b0011;
        tick();
        req_i = 4'b0110;
        tick();
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL clr_pre_gnt: got %b expected %b", gnt_o, 4'b0001); end
        req_i = 4'b0010;
        clr_i = 4'b0010;
        tick();
        req_i = 4'b0000;
        clr_i = 4'b0000;
        sel_i = 2'd1;
        #1;
        n_checks++; if (gnt_o !== 4'b0100) begin n_fail++; $display("[TB] FAIL clr_gnt_next: got %b expected %b", gnt_o, 4'b0100); end
        n_checks++; if (rd_data_o !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_ctr1: got %0d expected 0", rd_data_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_pend_gone: got %b expected 0", busy_o); end
        sel_i = 2'd2;
        tick();
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL clr_no_replay: got %b expected %b", gnt_o, 4'b0000); end
        n_checks++; if (rd_data_o !== 8'd1) begin n_fail++; $display("[TB] FAIL clr_ctr2: got %0d expected 1", rd_data_o); end
    endtask

    task automatic test_mid_reset();
        $display("[TB] test_mid_reset");
        req_i = 4'b1111;
        for (int k = 0; k < 8; k++) tick();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_busy_pre: got %b expected 1", busy_o); end
        n_checks++; if (drop_o !== 4'b1111) begin n_fail++; $display("[TB] FAIL mid_drop_pre: got %b expected %b", drop_o, 4'b1111); end
        req_i = 4'b0000;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_gnt: got %b expected %b", gnt_o, 4'b0000); end
        n_checks++; if (drop_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_drop: got %b expected %b", drop_o, 4'b0000); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy: got %b expected 0", busy_o); end
        n_checks++; if (rd_data_o !== 8'd0) begin n_fail++; $display("[TB] FAIL mid_rd: got %0d expected 0", rd_data_o); end
        tick();
        tick();
        #2 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_quiet_gnt_%0d: got %b expected %b", k, gnt_o, 4'b0000); end
            n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_quiet_busy_%0d: got %b expected 0", k, busy_o); end
        end
        sel_i = 2'd1;
        req_i = 4'b0010;
        tick();
        req_i = 4'b0000;
        tick();
        n_checks++; if (gnt_o !== 4'b0010) begin n_fail++; $display("[TB] FAIL mid_new_gnt: got %b expected %b", gnt_o, 4'b0010); end
        n_checks++; if (rd_data_o !== 8'd1) begin n_fail++; $display("[TB] FAIL mid_new_ctr: got %0d expected 1", rd_data_o); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_fairness();
        test_pending_balance();
        test_clear_collision();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
